eth_tx_sched: RTL and testbench
===============================

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 The block SHALL have parameter NLP_PERIOD, default 320000, giving the link-pulse interval in clk cycles (16 ms at 20 MHz).
REQ-002 The block SHALL have parameter IPG_CYCLES, default 192, giving the inter-packet gap in clk cycles (9.6 us at 20 MHz).
REQ-003 The block SHALL have parameter START_TO, default 64, giving the maximum cycles from tx_go to tx_w rising.
REQ-004 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-005 The block SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, 2, frame requests, one bit per requester, level.
REQ-007 The block SHALL have port gnt, output, 2, one-hot grant, held for the whole frame.
REQ-008 The block SHALL have port tx_go, output, 1, one-cycle pulse that starts the frame datapath.
REQ-009 The block SHALL have port tx_w, input, 1, frame datapath busy, high while the frame is on the wire.
REQ-010 The block SHALL have port nlp_go, output, 1, one-cycle pulse that fires the normal link pulse generator.
REQ-011 The block SHALL have port tx_err, output, 1, one-cycle pulse on start timeout.
REQ-012 The block SHALL have port led_tx, output, 1, active-low activity indicator.

Function
REQ-013 The block SHALL implement the FSM states IDLE, START, FRAME, IPG and NLP.
REQ-014 In IDLE with the NLP pending flag set, the block SHALL enter NLP, pulse nlp_go for 1 cycle, clear the pending flag and go to IPG on the next cycle.
- NLP has priority over a simultaneous req.
REQ-015 In IDLE with no NLP pending and any req bit high, the block SHALL select a requester by round-robin, assert the one-hot gnt, pulse tx_go for 1 cycle and enter START on the same edge.
- Round-robin order: the requester not granted last wins when both requests are asserted.
- The pointer after reset favours req[0].
REQ-016 In START, the block SHALL count cycles and enter FRAME on the first cycle tx_w is sampled high.
REQ-017 If tx_w is not sampled high within START_TO cycles after tx_go, the block SHALL pulse tx_err for 1 cycle, deassert gnt, not update the round-robin pointer and enter IPG.
REQ-018 In FRAME, the block SHALL hold gnt regardless of req, and on tx_w sampled low it SHALL deassert gnt, update the round-robin pointer and enter IPG.
REQ-019 In IPG, the block SHALL count exactly IPG_CYCLES cycles with gnt=0 before returning to IDLE, and it SHALL ignore req during the count.
- A new tx_go occurs no earlier than IPG_CYCLES+1 cycles after the falling edge of tx_w.
REQ-020 The NLP timer SHALL count NLP_PERIOD cycles and, on expiry, set the pending flag and reload.
- It also reloads on every nlp_go and on every completed frame (FRAME->IPG), because a frame substitutes for a link pulse.
REQ-021 An NLP timer expiry during START, FRAME or IPG SHALL only set the pending flag, and the pulse SHALL be issued at the next IDLE.
- If the frame completes in the same cycle as an expiry, the reload wins and the pending flag stays clear.
REQ-022 The block SHALL never assert nlp_go and tx_go in the same cycle, and it SHALL never assert nlp_go while gnt is non-zero.
REQ-023 The block SHALL drive led_tx = 0 while in START or FRAME and 1 otherwise, as a registered output.
REQ-024 The block SHALL size the counters at $clog2 of the maximum parameter value plus 1 and SHALL never let them wrap.
REQ-025 The block SHALL register all outputs.

Reset
REQ-026 While resetn=0, the block SHALL asynchronously force state IDLE, gnt=2'b00, tx_go=0, nlp_go=0, tx_err=0, led_tx=1, the round-robin pointer to favour req[0], all counters to 0 and the pending flag to 0.
REQ-027 After resetn is released, the first nlp_go SHALL occur NLP_PERIOD cycles later if no frame intervenes.
REQ-028 A reset asserted mid-frame SHALL abort the scheduling immediately with no tx_err.

Verification
REQ-029 The bench SHALL cover idle link: no req -> nlp_go pulses exactly every NLP_PERIOD cycles, with gnt=0 throughout.
REQ-030 The bench SHALL cover a single frame: req=01 -> gnt=01 and tx_go in the same cycle; tx_w high 100 cycles -> gnt=00 after the fall, next tx_go at least 193 cycles after the tx_w fall.
REQ-031 The bench SHALL cover both requesters held: req=11 continuously -> grants alternate 01,10,01,10, each separated by IPG.
REQ-032 The bench SHALL cover an NLP collision: the timer expires mid-frame -> no nlp_go until IDLE; a timer expiring in the same cycle as frame completion -> no nlp_go, and the next nlp_go arrives NLP_PERIOD cycles after the frame end.
REQ-033 The bench SHALL cover a start timeout: tx_w held 0 after tx_go -> tx_err pulse at cycle START_TO, gnt=00, and the same requester is granted again after IPG.
REQ-034 The bench SHALL cover a mid-frame reset: resetn low during FRAME -> all outputs at reset values in the same cycle, and normal operation after release.

Source files
------------

// File: rtl/eth_tx_sched.sv
// Ethernet transmit scheduler: round-robin frame grants for two requesters,
// inter-packet gap enforcement, start timeout and normal-link-pulse timing.
module eth_tx_sched #(
  parameter int NLP_PERIOD = 320000,
  parameter int IPG_CYCLES = 192,
  parameter int START_TO   = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       tx_go,
  input  logic       tx_w,
  output logic       nlp_go,
  output logic       tx_err,
  output logic       led_tx
);

  localparam int SEQ_MAX = (IPG_CYCLES > START_TO) ? IPG_CYCLES : START_TO;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int NLP_W   = $clog2(NLP_PERIOD + 1);

  // Expiry fires two cycles early: one IDLE cycle sees the pending flag and
  // the next edge registers nlp_go, so pulses land exactly NLP_PERIOD apart.
  localparam logic [NLP_W-1:0] NLP_EXP    = NLP_W'(NLP_PERIOD - 2);
  localparam logic [SEQ_W-1:0] START_LAST = SEQ_W'(START_TO - 1);
  localparam logic [SEQ_W-1:0] IPG_LAST   = SEQ_W'(IPG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, FRAME, IPG, NLP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               tx_go_q, tx_go_d;
  logic               nlp_go_q, nlp_go_d;
  logic               tx_err_q, tx_err_d;
  logic               led_tx_q, led_tx_d;
  logic               last_q, last_d;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic [NLP_W-1:0]   nlp_cnt_q, nlp_cnt_d;
  logic               nlp_pend_q, nlp_pend_d;
  logic               nlp_expire;
  logic [1:0]         pick;

  always_comb begin
    // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
    pick = 2'b10;
    if (req[0] && req[1]) begin
      pick = last_q ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      pick = 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    tx_go_d    = 1'b0;
    nlp_go_d   = 1'b0;
    tx_err_d   = 1'b0;
    last_d     = last_q;
    seq_cnt_d  = seq_cnt_q;
    nlp_pend_d = nlp_pend_q;
    nlp_expire = (nlp_cnt_q == NLP_EXP);
    nlp_cnt_d  = nlp_expire ? '0 : nlp_cnt_q + NLP_W'(1);
    if (nlp_expire) begin
      nlp_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (nlp_pend_q) begin
          state_d    = NLP;
          nlp_go_d   = 1'b1;
          nlp_pend_d = 1'b0;
          nlp_cnt_d  = '0;
        end else if (|req) begin
          state_d   = START;
          gnt_d     = pick;
          tx_go_d   = 1'b1;
          seq_cnt_d = '0;
        end
      end
      START: begin
        if (tx_w) begin
          state_d = FRAME;
        end else if (seq_cnt_q == START_LAST) begin
          state_d   = IPG;
          gnt_d     = 2'b00;
          tx_err_d  = 1'b1;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      FRAME: begin
        // A completed frame stands in for a link pulse; its reload beats a
        // simultaneous expiry, but an earlier pending pulse is kept.
        if (!tx_w) begin
          state_d    = IPG;
          gnt_d      = 2'b00;
          last_d     = gnt_q[1];
          seq_cnt_d  = '0;
          nlp_cnt_d  = '0;
          nlp_pend_d = nlp_pend_q;
        end
      end
      IPG: begin
        if (seq_cnt_q == IPG_LAST) begin
          state_d = IDLE;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      NLP: begin
        state_d   = IPG;
        seq_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    led_tx_d = !((state_d == START) || (state_d == FRAME));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      tx_go_q    <= 1'b0;
      nlp_go_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      led_tx_q   <= 1'b1;
      last_q     <= 1'b1;
      seq_cnt_q  <= '0;
      nlp_cnt_q  <= '0;
      nlp_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      tx_go_q    <= tx_go_d;
      nlp_go_q   <= nlp_go_d;
      tx_err_q   <= tx_err_d;
      led_tx_q   <= led_tx_d;
      last_q     <= last_d;
      seq_cnt_q  <= seq_cnt_d;
      nlp_cnt_q  <= nlp_cnt_d;
      nlp_pend_q <= nlp_pend_d;
    end
  end

  assign gnt    = gnt_q;
  assign tx_go  = tx_go_q;
  assign nlp_go = nlp_go_q;
  assign tx_err = tx_err_q;
  assign led_tx = led_tx_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: expected grants are queued as requests
// are driven and compared when tx_go appears; timing checks are inline.
module tb_eth_tx_sched;

  localparam int NLP_P = 2000;
  localparam int IPG   = 192;
  localparam int STO   = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [1:0] req = 2'b00;
  logic       tx_w = 1'b0;
  logic [1:0] gnt;
  logic       tx_go, nlp_go, tx_err, led_tx;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic [1:0] exp_gnt[$];

  eth_tx_sched #(
    .NLP_PERIOD(NLP_P),
    .IPG_CYCLES(IPG),
    .START_TO  (STO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .req   (req),
    .gnt   (gnt),
    .tx_go (tx_go),
    .tx_w  (tx_w),
    .nlp_go(nlp_go),
    .tx_err(tx_err),
    .led_tx(led_tx)
  );

  always #5 clk = ~clk;

  // Standing rules: no link pulse alongside a start or an open grant, one-hot gnt.
  always @(negedge clk) begin
    if (resetn) begin
      if (nlp_go && (tx_go || gnt != 2'b00)) viol++;
      if (gnt == 2'b11) viol++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    resetn = 1'b0;
    req    = 2'b00;
    tx_w   = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_tx_go(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tx_go) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_frame(input int len);
    tx_w = 1'b1;
    repeat (len) @(negedge clk);
    tx_w = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req    = 2'b00;
    tx_w   = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (tx_go !== 1'b0) begin failures++; $display("FAIL reset_tx_go: got %b expected 0", tx_go); end
    checks++; if (nlp_go !== 1'b0) begin failures++; $display("FAIL reset_nlp_go: got %b expected 0", nlp_go); end
    checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL reset_tx_err: got %b expected 0", tx_err); end
    checks++; if (led_tx !== 1'b1) begin failures++; $display("FAIL reset_led_tx: got %b expected 1", led_tx); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_idle_nlp();
    int pulses[$];
    int gbad;
    gbad = 0;
    apply_reset();
    for (int i = 1; i <= 3 * NLP_P + 5; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) gbad++;
      if (nlp_go) pulses.push_back(i);
    end
    checks++; if (pulses.size() != 3) begin failures++; $display("FAIL idle_pulse_count: got %0d expected 3", pulses.size()); end
    if (pulses.size() >= 1) begin
      checks++; if (pulses[0] != NLP_P) begin failures++; $display("FAIL idle_first_nlp: got %0d expected %0d", pulses[0], NLP_P); end
    end
    if (pulses.size() >= 3) begin
      checks++; if (pulses[1] - pulses[0] != NLP_P) begin failures++; $display("FAIL idle_period1: got %0d expected %0d", pulses[1] - pulses[0], NLP_P); end
      checks++; if (pulses[2] - pulses[1] != NLP_P) begin failures++; $display("FAIL idle_period2: got %0d expected %0d", pulses[2] - pulses[1], NLP_P); end
    end
    checks++; if (gbad != 0) begin failures++; $display("FAIL idle_gnt_zero: got %0d nonzero samples expected 0", gbad); end
  endtask

  task automatic test_single_frame();
    int n;
    logic [1:0] e;
    apply_reset();
    req = 2'b01;
    exp_gnt.push_back(2'b01);
    wait_tx_go(20, n);
    checks++;
    if (n < 0) begin
      failures++; $display("FAIL single_tx_go: got none expected pulse within 20");
      void'(exp_gnt.pop_front());
    end else begin
      e = exp_gnt.pop_front();
      if (gnt !== e) begin failures++; $display("FAIL single_gnt: got %b expected %b", gnt, e); end
      checks++; if (led_tx !== 1'b0) begin failures++; $display("FAIL single_led_start: got %b expected 0", led_tx); end
      tx_w = 1'b1;
      repeat (50) @(negedge clk);
      req = 2'b10;
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt_hold: got %b expected 01", gnt); end
      req = 2'b01;
      repeat (49) @(negedge clk);
      tx_w = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_release: got %b expected 00", gnt); end
      checks++; if (led_tx !== 1'b1) begin failures++; $display("FAIL single_led_ipg: got %b expected 1", led_tx); end
      exp_gnt.push_back(2'b01);
      wait_tx_go(IPG + 20, n);
      checks++;
      if (n < 0) begin
        failures++; $display("FAIL single_next_tx_go: got none expected pulse after gap");
        void'(exp_gnt.pop_front());
      end else begin
        // tx_go cycle measured from the first cycle tx_w is low
        if (n + 1 < IPG + 1 || n + 1 > IPG + 2) begin
          failures++; $display("FAIL single_gap: got %0d expected %0d..%0d", n + 1, IPG + 1, IPG + 2);
        end
        e = exp_gnt.pop_front();
        checks++; if (gnt !== e) begin failures++; $display("FAIL single_gnt2: got %b expected %b", gnt, e); end
        do_frame(5);
      end
    end
    req = 2'b00;
    repeat (IPG + 5) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] e;
    apply_reset();
    req = 2'b11;
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_tx_go(IPG + 50, n);
      e = exp_gnt.pop_front();
      checks++;
      if (n < 0) begin
        failures++; $display("FAIL rr_tx_go%0d: got none expected grant %b", k, e);
      end else begin
        if (gnt !== e) begin failures++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, e); end
        if (k > 0) begin
          checks++; if (n < IPG + 1) begin failures++; $display("FAIL rr_gap%0d: got %0d expected >= %0d", k, n, IPG + 1); end
        end
        do_frame(20);
      end
    end
    req = 2'b00;
    repeat (IPG + 5) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    int m;
    logic [1:0] e;
    apply_reset();
    req = 2'b11;
    exp_gnt.push_back(2'b01);
    wait_tx_go(20, n);
    e = exp_gnt.pop_front();
    checks++;
    if (n < 0) begin
      failures++; $display("FAIL to_tx_go: got none expected grant %b", e);
    end else begin
      if (gnt !== e) begin failures++; $display("FAIL to_gnt: got %b expected %b", gnt, e); end
      m = -1;
      for (int i = 1; i <= STO + 5; i++) begin
        @(negedge clk);
        if (tx_err) begin
          m = i;
          break;
        end
      end
      checks++; if (m != STO) begin failures++; $display("FAIL to_err_cycle: got %0d expected %0d", m, STO); end
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL to_gnt_clear: got %b expected 00", gnt); end
      checks++; if (led_tx !== 1'b1) begin failures++; $display("FAIL to_led: got %b expected 1", led_tx); end
      @(negedge clk);
      checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL to_err_width: got %b expected 0", tx_err); end
      exp_gnt.push_back(2'b01);
      wait_tx_go(IPG + 20, n);
      e = exp_gnt.pop_front();
      checks++;
      if (n < 0) begin
        failures++; $display("FAIL to_regrant: got none expected grant %b", e);
      end else begin
        if (gnt !== e) begin failures++; $display("FAIL to_regrant_gnt: got %b expected %b", gnt, e); end
        do_frame(10);
      end
    end
    req = 2'b00;
    repeat (IPG + 5) @(negedge clk);
  endtask

  task automatic test_nlp_collision();
    int n;
    int m;
    int nl;
    int tgo;
    logic [1:0] e;
    // Expiry inside a long frame: pulse deferred to the next IDLE, ahead of req.
    apply_reset();
    req = 2'b01;
    exp_gnt.push_back(2'b01);
    wait_tx_go(20, n);
    e = exp_gnt.pop_front();
    checks++;
    if (n < 0) begin
      failures++; $display("FAIL col_a_tx_go: got none expected grant %b", e);
    end else begin
      if (gnt !== e) begin failures++; $display("FAIL col_a_gnt: got %b expected %b", gnt, e); end
      nl = 0;
      tx_w = 1'b1;
      repeat (NLP_P + 100) begin
        @(negedge clk);
        if (nlp_go) nl++;
      end
      tx_w = 1'b0;
      checks++; if (nl != 0) begin failures++; $display("FAIL col_a_nlp_in_frame: got %0d expected 0", nl); end
      m = -1;
      tgo = 0;
      for (int i = 1; i <= IPG + 20; i++) begin
        @(negedge clk);
        if (tx_go) tgo++;
        if (nlp_go) begin
          m = i;
          break;
        end
      end
      req = 2'b00;
      checks++; if (m != IPG + 2) begin failures++; $display("FAIL col_a_nlp_at_idle: got %0d expected %0d", m, IPG + 2); end
      checks++; if (tgo != 0) begin failures++; $display("FAIL col_a_priority: got %0d tx_go expected 0", tgo); end
    end
    req = 2'b00;
    repeat (IPG + 5) @(negedge clk);

    // Frame completion on the very edge the timer expires: no pulse, reload.
    apply_reset();
    req = 2'b01;
    exp_gnt.push_back(2'b01);
    wait_tx_go(5, n);
    e = exp_gnt.pop_front();
    checks++;
    if (n != 1) begin
      failures++; $display("FAIL col_b_tx_go: got %0d expected 1", n);
    end else begin
      checks++; if (gnt !== e) begin failures++; $display("FAIL col_b_gnt: got %b expected %b", gnt, e); end
      tx_w = 1'b1;
      nl = 0;
      repeat (NLP_P - 3) begin
        @(negedge clk);
        if (nlp_go) nl++;
      end
      tx_w = 1'b0;
      req = 2'b00;
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL col_b_gnt_release: got %b expected 00", gnt); end
      m = -1;
      for (int i = 1; i <= NLP_P + 10; i++) begin
        @(negedge clk);
        if (nlp_go) begin
          m = i;
          break;
        end
      end
      checks++; if (nl != 0) begin failures++; $display("FAIL col_b_nlp_in_frame: got %0d expected 0", nl); end
      checks++; if (m != NLP_P) begin failures++; $display("FAIL col_b_next_nlp: got %0d expected %0d", m, NLP_P); end
    end
    req = 2'b00;
    repeat (IPG + 5) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n;
    int errs;
    logic [1:0] e;
    apply_reset();
    req = 2'b11;
    exp_gnt.push_back(2'b01);
    wait_tx_go(20, n);
    e = exp_gnt.pop_front();
    checks++;
    if (n < 0) begin
      failures++; $display("FAIL mr_tx_go: got none expected grant %b", e);
    end else begin
      if (gnt !== e) begin failures++; $display("FAIL mr_gnt: got %b expected %b", gnt, e); end
      tx_w = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (led_tx !== 1'b0) begin failures++; $display("FAIL mr_led_frame: got %b expected 0", led_tx); end
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL mr_gnt_async: got %b expected 00", gnt); end
      checks++; if (led_tx !== 1'b1) begin failures++; $display("FAIL mr_led_async: got %b expected 1", led_tx); end
      checks++; if ({tx_go, nlp_go, tx_err} !== 3'b000) begin failures++; $display("FAIL mr_pulses_async: got %b expected 000", {tx_go, nlp_go, tx_err}); end
      errs = 0;
      repeat (3) begin
        @(negedge clk);
        if (tx_err) errs++;
      end
      tx_w = 1'b0;
      resetn = 1'b1;
      exp_gnt.push_back(2'b01);
      wait_tx_go(20, n);
      e = exp_gnt.pop_front();
      checks++;
      if (n < 0) begin
        failures++; $display("FAIL mr_regrant: got none expected grant %b", e);
      end else begin
        if (gnt !== e) begin failures++; $display("FAIL mr_regrant_gnt: got %b expected %b", gnt, e); end
        do_frame(5);
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL mr_no_err: got %0d expected 0", errs); end
    end
    req = 2'b00;
    repeat (IPG + 5) @(negedge clk);
  endtask

  task automatic test_invariants();
    checks++; if (viol != 0) begin failures++; $display("FAIL invariants: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_idle_nlp();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_nlp_collision();
    test_mid_reset();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
